// File: rtl/cbb_count_ones_arb.sv
// cbb_count_ones_arb: round-robin arbiter that shares one popcount among
// N_REQ valid/ready requesters. It returns the count and the requester id
// through a single registered, back-pressurable response port.

// Popcount of one word. The result is zero-extended and never saturates:
// an all-ones word returns WIDTH.
module cbb_count_ones #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  // Sum the individual bits of the word into the count.
  always_comb begin
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(data[i]);
    end
  end

endmodule

module cbb_count_ones_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CNT_W-1:0]         rsp_cnt,
  output logic [IDX_W-1:0]         rsp_id
);

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] ptr_nxt_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic [IDX_W-1:0] cand_s;
  logic [N_REQ-1:0] grant_s;
  logic             slot_free_s;
  logic             any_grant_s;
  logic [WIDTH-1:0] sel_word_s;
  logic [CNT_W-1:0] pop_s;

  // The response slot can take a new result when it is empty or drains now.
  assign slot_free_s = !rsp_valid || rsp_ready;
  assign any_grant_s = |grant_s;
  assign req_ready   = grant_s;
  assign ptr_nxt_s   = IDX_W'((int'(gnt_idx_s) + 32'sd1) % N_REQ);

  // Round-robin pick. The scan runs from the farthest candidate back to ptr,
  // so the last hit is the first valid index at or after ptr.
  always_comb begin
    grant_s   = {N_REQ{1'b0}};
    gnt_idx_s = {IDX_W{1'b0}};
    cand_s    = {IDX_W{1'b0}};
    if (!rst && slot_free_s) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand_s = IDX_W'((int'(ptr_r) + k) % N_REQ);
        if (req_valid[cand_s]) begin
          grant_s         = {N_REQ{1'b0}};
          grant_s[cand_s] = 1'b1;
          gnt_idx_s       = cand_s;
        end else begin
          grant_s   = grant_s;
          gnt_idx_s = gnt_idx_s;
        end
      end
    end else begin
      grant_s   = {N_REQ{1'b0}};
      gnt_idx_s = {IDX_W{1'b0}};
    end
  end

  // Steer the granted requester's word into the shared popcount.
  always_comb begin
    sel_word_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        sel_word_s = req_data[i*WIDTH +: WIDTH];
      end else begin
        sel_word_s = sel_word_s;
      end
    end
  end

  cbb_count_ones #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_count_ones (
    .data (sel_word_s),
    .cnt  (pop_s)
  );

  // Response register and pointer. A grant loads a new result. A drain with
  // no grant only clears valid. Back-pressure freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_cnt   <= {CNT_W{1'b0}};
      rsp_id    <= {IDX_W{1'b0}};
      ptr_r     <= {IDX_W{1'b0}};
    end else if (any_grant_s) begin
      rsp_valid <= 1'b1;
      rsp_cnt   <= pop_s;
      rsp_id    <= gnt_idx_s;
      ptr_r     <= ptr_nxt_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

endmodule

// File: tb/tb_cbb_count_ones_arb.sv
// Directed bench for cbb_count_ones_arb (N_REQ=4, WIDTH=8). The stimulus pushes
// the hand-computed (id,cnt) of every expected grant into a scoreboard queue.
// A monitor pops and compares on each response transfer.
module tb_cbb_count_ones_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_cnt;
  logic [1:0]  rsp_id;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] sb_q[$];

  // bench model of the response register
  logic       m_rv;
  logic [1:0] m_id;
  logic [3:0] m_cnt;

  // requester-obligation tracking
  logic [3:0]  pend_q;
  logic [31:0] data_q;

  cbb_count_ones_arb #(.N_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_cnt   (rsp_cnt),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every response transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got id %0d cnt %0d expected none", rsp_id, rsp_cnt);
      end else begin
        logic [5:0] e;
        e = sb_q.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e[5:4]));
        chk("sb_cnt", 32'(rsp_cnt), 32'(e[3:0]));
      end
    end
  end

  // Requester obligation: a pending offer keeps valid high and data stable.
  always @(negedge clk) begin
    if (rst) begin
      pend_q = 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pend_q[i] && (!req_valid[i] || req_data[i*8 +: 8] !== data_q[i*8 +: 8])) begin
          n_err++;
          $display("FAIL obligation: requester %0d got valid %0b expected 1 with stable data", i, req_valid[i]);
        end
      end
      pend_q = req_valid & ~req_ready;
      data_q = req_data;
    end
  end

  // One cycle: check the grant and the register model, queue the expected response.
  task automatic step(input bit g, input int id, input int cnt);
    logic [3:0] exp_rdy;
    logic [1:0] id2;
    logic [3:0] cnt4;
    id2 = id[1:0];
    cnt4 = cnt[3:0];
    exp_rdy = g ? (4'b0001 << id) : 4'b0000;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_cnt", 32'(rsp_cnt), 32'(m_cnt));
    if (g) begin
      sb_q.push_back({id2, cnt4});
      m_rv = 1'b1;
      m_id = id2;
      m_cnt = cnt4;
    end else if (rsp_ready) begin
      m_rv = 1'b0;
    end else begin
      m_rv = m_rv;
    end
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_rv = 1'b0; m_id = 2'd0; m_cnt = 4'd0;
    rst = 1'b1;
    req_valid = 4'($urandom);
    req_data = $urandom;
    rsp_ready = 1'($urandom);
    @(posedge clk);
    #1;
    // reset values with random inputs
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'($urandom);
      req_data = $urandom;
      rsp_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_cnt", 32'(rsp_cnt), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end

    // round-robin sweep
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_data = {8'hFF, 8'hF0, 8'hAA, 8'h00};
    step(1'b1, 0, 0);
    step(1'b1, 1, 4);
    step(1'b1, 2, 4);
    step(1'b1, 3, 8);
    step(1'b1, 0, 0);
    step(1'b1, 1, 4);

    // back-pressure: five frozen cycles, then drain and grant the next id together
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) step(1'b0, 0, 0);
    rsp_ready = 1'b1;
    step(1'b1, 2, 4);

    // pointer wrap and sparse requests
    req_valid = 4'b1011;
    step(1'b1, 3, 8);
    step(1'b1, 0, 0);
    req_valid = 4'b1010;
    step(1'b1, 1, 4);
    step(1'b1, 3, 8);
    step(1'b1, 1, 4);
    req_valid = 4'b1000;
    step(1'b1, 3, 8);
    req_valid = 4'b0000;
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);

    // single requester 2 with 8'b10101010
    req_data = {8'hFF, 8'b10101010, 8'hAA, 8'h00};
    req_valid = 4'b0100;
    step(1'b1, 2, 4);

    // hold the response, then reset mid-stream
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    step(1'b0, 0, 0);
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = {8'hFF, 8'hF0, 8'hAA, 8'h00};
    rsp_ready = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_rv = 1'b0; m_id = 2'd0; m_cnt = 4'd0;
    step(1'b1, 0, 0);
    req_valid = 4'b1110;
    step(1'b1, 1, 4);
    req_valid = 4'b1100;
    step(1'b1, 2, 4);
    req_valid = 4'b1000;
    step(1'b1, 3, 8);
    req_valid = 4'b0000;
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cbb_count_ones_arb.md
# cbb_count_ones_arb

Round-robin arbiter that shares a single `CBB_COUNT_ONES` popcount instance among `N_REQ` requesters, each offering a `WIDTH`-bit word over a valid/ready handshake. The winning word is popcounted in the grant cycle. The count and the requester index are returned through one registered, back-pressurable response port. It sits in the CBB library, next to the popcount, for sort-stage logic that needs occasional bit counts without replicating the adder tree.

## Interface
- `N_REQ`, 4 — number of requesters, ≥1.
- `WIDTH`, 8 — word width per requester; passed to `CBB_COUNT_ONES`.
- `CNT_W`, `$clog2(WIDTH)+1` — count width; holds 0..`WIDTH` inclusive.
- `IDX_W`, `(N_REQ>1)?$clog2(N_REQ):1` — requester index width.

- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst` in 1 — reset; synchronous, active-high.
- `req_valid` in `N_REQ` — bit i: requester i offers a word.
- `req_data` in `N_REQ*WIDTH` — requester i word at `[i*WIDTH +: WIDTH]`.
- `req_ready` out `N_REQ` — one-hot or zero; bit i high means requester i is granted and transfers this cycle.
- `rsp_valid` out 1 — response register holds a result.
- `rsp_ready` in 1 — consumer accepts the response.
- `rsp_cnt` out `CNT_W` — number of 1 bits in the granted word.
- `rsp_id` out `IDX_W` — index of the requester that produced `rsp_cnt`.

## Operation
- **Internal state:**
  - round-robin pointer `ptr` (`IDX_W` bits), which is the highest-priority index;
  - response register `{rsp_valid, rsp_cnt, rsp_id}`.
- **`slot_free`** = `!rsp_valid || rsp_ready`.
- **Grant (combinational):**
  - If `slot_free` and any `req_valid` is set, grant the first valid index found scanning `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1`.
  - Assert only that bit of `req_ready`.
  - Otherwise `req_ready` = 0.
  - `req_ready[i]` never rises without `req_valid[i]`.
- **Datapath:**
  - A single `CBB_COUNT_ONES` instance is fed by a mux that selects the granted requester's `req_data` slice.
  - No other popcount logic is present.
- **On a grant to index g:**
  - `rsp_cnt` ← popcount(word g), `rsp_id` ← g, `rsp_valid` ← 1;
  - `ptr` ← (g+1) mod `N_REQ`.
- **Response drained (`rsp_valid && rsp_ready`) with no grant:** `rsp_valid` ← 0; `rsp_cnt`/`rsp_id` hold their last values.
- **Back-pressure (`rsp_valid && !rsp_ready`):**
  - `rsp_cnt`, `rsp_id` and `ptr` are frozen; `req_ready` = 0.
- **Requester obligation:** once `req_valid[i]` is asserted, it stays high with `req_data` slice i stable until `req_ready[i]`. The bench asserts this on its own drivers; the block does not check it.
- **Fairness:** a requester holding `req_valid` continuously is granted within `N_REQ` grants.
- **Width rule:** `rsp_cnt` is zero-extended popcount. With `WIDTH`=8 an all-ones word returns 4'b1000; there is no saturation or wrap.
- **`N_REQ`=1:** `ptr` is constant 0, `rsp_id` is 0, and the block degenerates to a registered popcount with handshake.

## Timing
- **Reset (`rst`=1 at a clock edge):**
  - `rsp_valid`=0, `rsp_cnt`=0, `rsp_id`=0, `ptr`=0;
  - `req_ready`=0 while `rst` is high.
- **Mid-operation reset:** an un-drained response is discarded. The first grant after release favours requester 0.
- **Latency:** the grant in cycle T makes `rsp_valid` visible in cycle T+1, carrying that word's count.
- **Throughput:** one grant per cycle while `rsp_ready` is held high.
- **Drain and grant in the same cycle:** the register reloads with no bubble and `rsp_valid` stays 1.
- **`rsp_ready` low for k cycles:** zero grants occur in those cycles; grants resume in the cycle `rsp_ready` returns high.
- **No `req_valid` with `slot_free`:** no grant and `ptr` unchanged. If the old response is drained, `rsp_valid` falls the next cycle.
- **Combinational paths:**
  - `req_ready` depends on `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`;
  - the `rsp_*` outputs are pure register outputs.

## Test plan
- **Reset values:** hold `rst` 3 cycles with random inputs → `rsp_valid`=0, `rsp_cnt`=0, `rsp_id`=0 and `req_ready`=0 every cycle. After release, set all `req_valid`=1 → first grant goes to requester 0.
- **Single requester:** only requester 2 valid with 8'b10101010, `rsp_ready`=1 → `req_ready`=4'b0100 in cycle T. In T+1, `rsp_valid`=1, `rsp_cnt`=4, `rsp_id`=2.
- **Round-robin sweep:** all 4 requesters valid continuously with data 8'h00, 8'hAA, 8'hF0, 8'hFF, `rsp_ready`=1:
  - grants in order 0,1,2,3,0,…, one per cycle;
  - responses (id,cnt) = (0,0), (1,4), (2,4), (3,8), repeating;
  - `rsp_cnt`=4'b1000 for id 3.
- **Back-pressure:** during the sweep drop `rsp_ready` for 5 cycles → `req_ready`=0 and `rsp_*` frozen for those cycles. When `rsp_ready` rises, the held response drains and the next id in rotation is granted the same cycle, with no skipped or duplicated id.
- **Pointer wrap and sparse requests:** after a grant to 3, only requesters 1 and 3 valid → 1 is granted, then 3, then 1. No grant goes to an invalid index.
- **Reset mid-stream:** assert `rst` for 1 cycle while `rsp_valid`=1 and `rsp_ready`=0 → next cycle `rsp_valid`=0. The first post-reset grant follows `ptr`=0 priority.
